// File: rtl/bus_timer_slave_if.sv
// Simple strobe-based register bus; the "in" modport is the slave's view of it.
interface bus_slave;
  logic        wr;
  logic        rd;
  logic [31:0] addr;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport in  (input wr, input rd, input addr, input data_i, output data_o);
  modport out (output wr, output rd, output addr, output data_i, input data_o);
endinterface

// File: rtl/bus_timer_slave.sv
// Register-mapped down-counting timer with prescaler and level interrupt on expiry.
// Template slave on the bus_slave interface: single-cycle registered reads, no wait states.
module bus_timer_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned PRE_W     = 16
) (
  input  logic clk,
  input  logic rst,
  bus_slave.in bus,
  output logic irq
);

  typedef enum logic [2:0] {
    REG_CTRL     = 3'd0,
    REG_LOAD     = 3'd1,
    REG_COUNT    = 3'd2,
    REG_STATUS   = 3'd3,
    REG_PRESCALE = 3'd4
  } reg_idx_e;

  logic [2:0]       ctrl_q, ctrl_d;
  logic [CNT_W-1:0] load_q, load_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             expired_q, expired_d;
  logic [PRE_W-1:0] prescale_q, prescale_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [31:0]      data_o_q, data_o_d;
  logic             irq_q, irq_d;

  logic       hit;
  logic       wr_hit;
  logic [2:0] idx;
  logic       tick;
  logic       load_wr;
  logic [31:0] rd_data;

  // Byte-lane bits and unused data bits are intentionally ignored.
  logic unused_bus;
  assign unused_bus = ^{bus.addr[1:0], bus.data_i};

  always_comb begin
    hit     = (bus.addr[31:5] == BASE_ADDR[31:5]);
    idx     = bus.addr[4:2];
    wr_hit  = bus.wr & hit;
    load_wr = wr_hit && (idx == REG_LOAD);
    tick    = ctrl_q[0] && (pre_q == prescale_q);

    rd_data = '0;
    if (hit) begin
      case (idx)
        REG_CTRL:     rd_data[2:0]       = ctrl_q;
        REG_LOAD:     rd_data[CNT_W-1:0] = load_q;
        REG_COUNT:    rd_data[CNT_W-1:0] = count_q;
        REG_STATUS:   rd_data[0]         = expired_q;
        REG_PRESCALE: rd_data[PRE_W-1:0] = prescale_q;
        default:      rd_data            = '0;
      endcase
    end
  end

  always_comb begin
    ctrl_d     = ctrl_q;
    load_d     = load_q;
    count_d    = count_q;
    expired_d  = expired_q;
    prescale_d = prescale_q;
    pre_d      = pre_q;

    if (ctrl_q[0])
      pre_d = tick ? '0 : pre_q + PRE_W'(1);

    // Ordering encodes priority: W1C first so a same-cycle expiry still sets
    // the flag; bus writes last so they win for EN, COUNT and the prescaler.
    if (wr_hit && (idx == REG_STATUS) && bus.data_i[0])
      expired_d = 1'b0;

    if (tick && !load_wr) begin
      if (count_q != '0) begin
        count_d = count_q - CNT_W'(1);
      end else begin
        expired_d = 1'b1;
        if (ctrl_q[1])
          count_d = load_q;
        else
          ctrl_d[0] = 1'b0;
      end
    end

    if (wr_hit) begin
      case (idx)
        REG_CTRL: ctrl_d = bus.data_i[2:0];
        REG_LOAD: begin
          load_d  = bus.data_i[CNT_W-1:0];
          count_d = bus.data_i[CNT_W-1:0];
          pre_d   = '0;
        end
        REG_PRESCALE: begin
          prescale_d = bus.data_i[PRE_W-1:0];
          pre_d      = '0;
        end
        default: ;
      endcase
    end

    data_o_d = bus.rd ? rd_data : data_o_q;
    irq_d    = expired_q & ctrl_q[2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q     <= '0;
      load_q     <= '0;
      count_q    <= '0;
      expired_q  <= 1'b0;
      prescale_q <= '0;
      pre_q      <= '0;
      data_o_q   <= '0;
      irq_q      <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      load_q     <= load_d;
      count_q    <= count_d;
      expired_q  <= expired_d;
      prescale_q <= prescale_d;
      pre_q      <= pre_d;
      data_o_q   <= data_o_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.data_o = data_o_q;
  assign irq        = irq_q;

endmodule

// File: doc/bus_timer_slave.md
Name: bus_timer_slave

Overview:
- Register-mapped down-counting timer peripheral; the first consumer of the bus_slave interface on its receiving side (modport in).
- Decodes word-aligned wr/rd strobes within its address window and exposes control, reload, count, status and prescaler registers.
- Raises a level interrupt on expiry.
- Serves as the template downstream slave for new peripherals.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte base address of the 32-byte register window (must be 32-byte aligned).
- CNT_W, 32, width of the LOAD and COUNT registers (1..32); upper data bits are read as 0 and ignored on write.
- PRE_W, 16, width of the PRESCALE register and the internal prescaler counter.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- bus  interface  -  bus_slave.in modport: wr, rd, addr[31:0], data_i[31:0] are inputs; data_o[31:0] is an output.
- irq  output  1  registered level interrupt.

Behaviour:
- Reset: data_o=0, irq=0, and CTRL, LOAD, COUNT, STATUS, PRESCALE and the prescaler counter are all 0.
- Decode: hit = addr[31:5]==BASE_ADDR[31:5]. The register index is addr[4:2]; addr[1:0] is ignored.
  - Offsets: 0x00 CTRL, 0x04 LOAD, 0x08 COUNT, 0x0C STATUS, 0x10 PRESCALE.
  - 0x14-0x1C are reserved: writes are ignored, reads return 0.
  - A miss performs no write, and data_o returns 0 on the following cycle if rd was high.
- CTRL (RW): bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN; other bits read 0.
- LOAD (RW): a write also copies the value into COUNT and clears the prescaler counter.
- COUNT (RO): writes are ignored.
- STATUS (bit0 EXPIRED): write-1-to-clear; writing 0 has no effect.
- PRESCALE (RW): a write clears the prescaler counter.
- Write: takes effect on the rising edge where wr=1 and hit.
- Read: data_o is registered and valid exactly 1 cycle after rd=1. data_o holds its last value while rd=0. There is no wait state and no handshake.
- wr and rd in the same cycle: the write is performed, and the read returns the pre-write value.
- Prescaler: while EN=1 it counts 0..PRESCALE. tick=1 when pre==PRESCALE, and pre then wraps to 0. PRESCALE=0 gives tick every cycle. While EN=0, pre holds.
- On tick:
  - If COUNT!=0: COUNT<=COUNT-1.
  - If COUNT==0: EXPIRED<=1. Then if AUTO_RELOAD=1, COUNT<=LOAD; otherwise EN<=0 (one-shot) and COUNT stays 0.
  - Period = (LOAD+1)*(PRESCALE+1) cycles.
- Simultaneous events:
  - Expiry and a STATUS W1C in the same cycle: set wins, EXPIRED=1.
  - Expiry and a CTRL write in the same cycle: the bus write wins for EN.
  - A LOAD write in the same cycle as a tick: the LOAD write wins for COUNT; no decrement and no expiry that cycle.
- irq: registered, irq <= EXPIRED & IRQ_EN, which gives 1 cycle of delay after the flag state.
- Reset mid-operation: all state returns immediately to reset values, asynchronously. The first bus access after rst deasserts is accepted on the first clk edge.

Test Plan:
- Reset values: assert rst, then read 0x00, 0x04, 0x08, 0x0C and 0x10 -> data_o=0 one cycle after each rd; irq=0.
- One-shot: write LOAD=3, PRESCALE=0, CTRL=0x5 -> COUNT reads 3,2,1,0 on successive cycles.
  - EXPIRED=1 four cycles after the EN write edge, and irq=1 one cycle later.
  - CTRL reads 0x4 (EN cleared); COUNT holds 0.
- Auto-reload with prescale: LOAD=2, PRESCALE=1, CTRL=0x3 -> EXPIRED first sets 6 cycles after enable.
  - COUNT then reloads to 2; write STATUS=1 and expiry recurs every 6 cycles.
- W1C race: schedule a STATUS=1 write on the exact expiry cycle -> EXPIRED reads 1. A W1C on a later cycle -> it reads 0, and irq drops 1 cycle after the flag clears.
- Decode: write 0xDEAD_BEEF to BASE_ADDR+0x20 and to 0x14 -> no register changes, and reads of both return 0.
  - Byte addresses BASE+0x05/0x06 -> access LOAD.
  - rd and wr same cycle on LOAD (old 7, new 9) -> data_o=7, and the next read gives 9.
- Async reset mid-count: assert rst between clock edges with COUNT=5 and EN=1 -> COUNT, CTRL, irq and data_o are 0 before the next edge, and the counter stays idle after release.
